// File: rtl/vtg_pkg.sv
// Shared timing record, 720p fallback timing and the config legality check
// used by video_timing_gen and its axis counters.
package vtg_pkg;

  // Record field width; X_BITS/Y_BITS of the generator must not exceed it.
  localparam int TW = 16;

  typedef struct packed {
    logic [TW-1:0] active;
    logic [TW-1:0] fp;
    logic [TW-1:0] sync;
    logic [TW-1:0] bp;
  } timing_t;

  localparam timing_t DEF_H = '{active: TW'(1280), fp: TW'(110), sync: TW'(40), bp: TW'(220)};
  localparam timing_t DEF_V = '{active: TW'(720),  fp: TW'(5),   sync: TW'(5),  bp: TW'(20)};

  function automatic logic [TW+1:0] ext(input logic [TW-1:0] v);
    return {2'b00, v};
  endfunction

  function automatic logic [TW+1:0] total_of(input timing_t t);
    return ext(t.active) + ext(t.fp) + ext(t.sync) + ext(t.bp);
  endfunction

  function automatic logic [TW+1:0] sync_lo_of(input timing_t t);
    return ext(t.active) + ext(t.fp);
  endfunction

  // Every field non-zero and the total must fit in 'bits' without a carry out.
  function automatic logic timing_legal(input timing_t t, input int unsigned bits);
    logic [TW+1:0] tot;
    tot = total_of(t);
    return (t.active != '0) && (t.fp != '0) && (t.sync != '0) && (t.bp != '0) &&
           ((tot >> bits) == '0);
  endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis: counts 0..total-1 on each advance strobe and decodes the
// active and sync windows of the current position.
module vtg_axis_counter
  import vtg_pkg::*;
#(
  parameter int W = 13
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic         adv_i,
  input  timing_t      cfg_i,
  output logic [W-1:0] cnt_o,
  output logic         active_o,
  output logic         sync_o,
  output logic         wrap_o
);

  logic [W-1:0]  cnt_q, cnt_d;
  logic [TW+1:0] cnt_ext, sync_lo;

  assign cnt_ext  = (TW+2)'(cnt_q);
  assign sync_lo  = sync_lo_of(cfg_i);
  assign cnt_o    = cnt_q;
  assign active_o = cnt_ext < ext(cfg_i.active);
  assign sync_o   = (cnt_ext >= sync_lo) && (cnt_ext < sync_lo + ext(cfg_i.sync));
  assign wrap_o   = cnt_ext == total_of(cfg_i) - (TW+2)'(1);

  always_comb begin
    cnt_d = cnt_q;
    if (adv_i) cnt_d = wrap_o ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: shadowed runtime timing applied at frame wrap,
// registered x/y/den/sync/frame_start outputs one cycle behind the counters.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int X_BITS = 13,
  parameter int Y_BITS = 13,
  parameter int DEF_HA = int'(DEF_H.active),
  parameter int DEF_HF = int'(DEF_H.fp),
  parameter int DEF_HS = int'(DEF_H.sync),
  parameter int DEF_HB = int'(DEF_H.bp),
  parameter int DEF_VA = int'(DEF_V.active),
  parameter int DEF_VF = int'(DEF_V.fp),
  parameter int DEF_VS = int'(DEF_V.sync),
  parameter int DEF_VB = int'(DEF_V.bp)
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              ce,
  input  logic [X_BITS-1:0] h_active,
  input  logic [X_BITS-1:0] h_fp,
  input  logic [X_BITS-1:0] h_sync,
  input  logic [X_BITS-1:0] h_bp,
  input  logic [Y_BITS-1:0] v_active,
  input  logic [Y_BITS-1:0] v_fp,
  input  logic [Y_BITS-1:0] v_sync,
  input  logic [Y_BITS-1:0] v_bp,
  input  logic              hs_pol,
  input  logic              vs_pol,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic              hn_out,
  output logic              vn_out,
  output logic              den_out,
  output logic [X_BITS-1:0] total_active_pix,
  output logic [Y_BITS-1:0] total_active_lines,
  output logic              frame_start,
  output logic              cfg_err
);

  localparam timing_t DEF_HT = '{active: TW'(DEF_HA), fp: TW'(DEF_HF), sync: TW'(DEF_HS), bp: TW'(DEF_HB)};
  localparam timing_t DEF_VT = '{active: TW'(DEF_VA), fp: TW'(DEF_VF), sync: TW'(DEF_VS), bp: TW'(DEF_VB)};

  timing_t           req_h, req_v, h_sh_q, h_sh_d, v_sh_q, v_sh_d;
  logic              cfg_ok, cfg_err_q, cfg_err_d;
  logic [X_BITS-1:0] h_cnt, x_q, x_d;
  logic [Y_BITS-1:0] v_cnt, y_q, y_d;
  logic              h_act, h_sync_w, h_wrap, v_act, v_sync_w, v_wrap;
  logic              frame_wrap, hs_start, vs_act, vs_state_q, vs_state_d;
  logic              den_q, den_d, hn_q, hn_d, vn_q, vn_d, fs_q, fs_d;

  assign req_h = '{active: TW'(h_active), fp: TW'(h_fp), sync: TW'(h_sync), bp: TW'(h_bp)};
  assign req_v = '{active: TW'(v_active), fp: TW'(v_fp), sync: TW'(v_sync), bp: TW'(v_bp)};
  assign cfg_ok     = timing_legal(req_h, X_BITS) && timing_legal(req_v, Y_BITS);
  assign frame_wrap = ce && h_wrap && v_wrap;

  vtg_axis_counter #(.W(X_BITS)) u_h_axis (
    .clk_in(clk_in), .reset(reset), .adv_i(ce), .cfg_i(h_sh_q),
    .cnt_o(h_cnt), .active_o(h_act), .sync_o(h_sync_w), .wrap_o(h_wrap)
  );

  vtg_axis_counter #(.W(Y_BITS)) u_v_axis (
    .clk_in(clk_in), .reset(reset), .adv_i(ce && h_wrap), .cfg_i(v_sh_q),
    .cnt_o(v_cnt), .active_o(v_act), .sync_o(v_sync_w), .wrap_o(v_wrap)
  );

  // Vsync only changes at the hsync leading edge; between edges it holds the
  // line's sync state latched at the previous edge.
  assign hs_start   = (TW+2)'(h_cnt) == sync_lo_of(h_sh_q);
  assign vs_act     = hs_start ? v_sync_w : vs_state_q;
  assign vs_state_d = (ce && hs_start) ? v_sync_w : vs_state_q;

  always_comb begin
    h_sh_d    = h_sh_q;
    v_sh_d    = v_sh_q;
    cfg_err_d = cfg_err_q;
    if (frame_wrap) begin
      cfg_err_d = !cfg_ok;
      if (cfg_ok) begin
        h_sh_d = req_h;
        v_sh_d = req_v;
      end
    end
  end

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    den_d = den_q;
    hn_d  = hn_q;
    vn_d  = vn_q;
    fs_d  = 1'b0;
    if (ce) begin
      x_d   = h_cnt;
      y_d   = v_cnt;
      den_d = h_act && v_act;
      hn_d  = ~(h_sync_w ^ hs_pol);
      vn_d  = ~(vs_act ^ vs_pol);
      fs_d  = (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      h_sh_q     <= cfg_ok ? req_h : DEF_HT;
      v_sh_q     <= cfg_ok ? req_v : DEF_VT;
      cfg_err_q  <= !cfg_ok;
      vs_state_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      den_q      <= 1'b0;
      hn_q       <= ~hs_pol;
      vn_q       <= ~vs_pol;
      fs_q       <= 1'b0;
    end else begin
      h_sh_q     <= h_sh_d;
      v_sh_q     <= v_sh_d;
      cfg_err_q  <= cfg_err_d;
      vs_state_q <= vs_state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      den_q      <= den_d;
      hn_q       <= hn_d;
      vn_q       <= vn_d;
      fs_q       <= fs_d;
    end
  end

  assign x                  = x_q;
  assign y                  = y_q;
  assign den_out            = den_q;
  assign hn_out             = hn_q;
  assign vn_out             = vn_q;
  assign frame_start        = fs_q;
  assign cfg_err            = cfg_err_q;
  assign total_active_pix   = X_BITS'(h_sh_q.active);
  assign total_active_lines = Y_BITS'(v_sh_q.active);

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: raster-position reference model
// compared every cycle, plus directed literal checks and randomized traffic.
module tb_video_timing_gen;

  localparam int XB = 13;
  localparam int YB = 13;

  logic          clk_in = 1'b0;
  logic          reset  = 1'b1;
  logic          ce     = 1'b0;
  logic [XB-1:0] h_active, h_fp, h_sync, h_bp;
  logic [YB-1:0] v_active, v_fp, v_sync, v_bp;
  logic          hs_pol = 1'b1;
  logic          vs_pol = 1'b1;
  logic [XB-1:0] x, total_active_pix;
  logic [YB-1:0] y, total_active_lines;
  logic          hn_out, vn_out, den_out, frame_start, cfg_err;

  video_timing_gen #(.X_BITS(XB), .Y_BITS(YB)) dut (
    .clk_in(clk_in), .reset(reset), .ce(ce),
    .h_active(h_active), .h_fp(h_fp), .h_sync(h_sync), .h_bp(h_bp),
    .v_active(v_active), .v_fp(v_fp), .v_sync(v_sync), .v_bp(v_bp),
    .hs_pol(hs_pol), .vs_pol(vs_pol),
    .x(x), .y(y), .hn_out(hn_out), .vn_out(vn_out), .den_out(den_out),
    .total_active_pix(total_active_pix), .total_active_lines(total_active_lines),
    .frame_start(frame_start), .cfg_err(cfg_err)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int nfail  = 0;
  bit chk_en = 0;
  int ce_mode = 0;  // 0: always on, 1: toggle, 2: random

  always @(negedge clk_in) begin
    case (ce_mode)
      0:       ce = 1'b1;
      1:       ce = ~ce;
      default: ce = ($urandom_range(3) != 0);
    endcase
  end

  // ---------------- reference model: linear position within the frame ----------------
  int m_h[4];
  int m_v[4];
  int m_p;
  logic          e_den, e_hn, e_vn, e_fs, e_err;
  logic [XB-1:0] e_x, e_tap;
  logic [YB-1:0] e_y, e_tal;

  function automatic bit legal4(int a, int b, int c, int d, int bits);
    return a > 0 && b > 0 && c > 0 && d > 0 && (a + b + c + d) < (1 << bits);
  endfunction

  function automatic bit ports_legal();
    return legal4(int'(h_active), int'(h_fp), int'(h_sync), int'(h_bp), XB) &&
           legal4(int'(v_active), int'(v_fp), int'(v_sync), int'(v_bp), YB);
  endfunction

  always @(posedge clk_in) begin : model
    int ht, vt, h, v, lo, hi;
    if (reset || ce) begin
      ht = m_h[0] + m_h[1] + m_h[2] + m_h[3];
      vt = m_v[0] + m_v[1] + m_v[2] + m_v[3];
    end
    if (reset) begin
      if (ports_legal()) begin
        m_h = '{int'(h_active), int'(h_fp), int'(h_sync), int'(h_bp)};
        m_v = '{int'(v_active), int'(v_fp), int'(v_sync), int'(v_bp)};
        e_err = 1'b0;
      end else begin
        m_h = '{1280, 110, 40, 220};
        m_v = '{720, 5, 5, 20};
        e_err = 1'b1;
      end
      m_p = 0;
      e_x = '0; e_y = '0; e_den = 1'b0; e_fs = 1'b0;
      e_hn = ~hs_pol; e_vn = ~vs_pol;
    end else if (ce) begin
      h = m_p % ht;
      v = m_p / ht;
      e_x   = XB'(h);
      e_y   = YB'(v);
      e_den = (h < m_h[0]) && (v < m_v[0]);
      e_hn  = (h >= m_h[0] + m_h[1] && h < m_h[0] + m_h[1] + m_h[2]) ? hs_pol : ~hs_pol;
      lo    = (m_v[0] + m_v[1]) * ht + m_h[0] + m_h[1];
      hi    = (m_v[0] + m_v[1] + m_v[2]) * ht + m_h[0] + m_h[1];
      e_vn  = (m_p >= lo && m_p < hi) ? vs_pol : ~vs_pol;
      e_fs  = (m_p == 0);
      if (m_p == ht * vt - 1) begin
        m_p = 0;
        if (ports_legal()) begin
          m_h = '{int'(h_active), int'(h_fp), int'(h_sync), int'(h_bp)};
          m_v = '{int'(v_active), int'(v_fp), int'(v_sync), int'(v_bp)};
          e_err = 1'b0;
        end else begin
          e_err = 1'b1;
        end
      end else begin
        m_p = m_p + 1;
      end
    end else begin
      e_fs = 1'b0;
    end
    e_tap = XB'(m_h[0]);
    e_tal = YB'(m_v[0]);
  end

  always @(negedge clk_in) begin
    if (chk_en) begin
      checks++;
      if (x !== e_x || y !== e_y || den_out !== e_den || hn_out !== e_hn || vn_out !== e_vn ||
          frame_start !== e_fs || total_active_pix !== e_tap || total_active_lines !== e_tal ||
          cfg_err !== e_err) begin
        errors++;
        if (nfail < 10)
          $display("FAIL model_cmp t=%0t (dut/model) x=%0d/%0d y=%0d/%0d den=%b/%b hn=%b/%b vn=%b/%b fs=%b/%b tap=%0d/%0d tal=%0d/%0d err=%b/%b",
                   $time, x, e_x, y, e_y, den_out, e_den, hn_out, e_hn, vn_out, e_vn,
                   frame_start, e_fs, total_active_pix, e_tap, total_active_lines, e_tal, cfg_err, e_err);
        nfail++;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("check %s: got %0d", name, act);
    end
  endtask

  task automatic set_cfg(input int ha, hf, hs, hb, va, vf, vs, vb);
    h_active = XB'(ha); h_fp = XB'(hf); h_sync = XB'(hs); h_bp = XB'(hb);
    v_active = YB'(va); v_fp = YB'(vf); v_sync = YB'(vs); v_bp = YB'(vb);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (frame_start !== 1'b1 && n < 20000);
    if (frame_start !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_fs: no frame_start within %0d cycles", n);
    end
  endtask

  // Entered on a frame_start cycle; returns on the next frame_start cycle.
  task automatic measure(output int len, dens, hns, vns, vfx, vfy, vlx, vly, output bit hn_at_vrise);
    len = 0; dens = 0; hns = 0; vns = 0; vfx = -1; vfy = -1; vlx = -1; vly = -1; hn_at_vrise = 0;
    do begin
      if (den_out) dens++;
      if (hn_out == hs_pol) hns++;
      if (vn_out == vs_pol) begin
        if (vns == 0) begin
          vfx = int'(x); vfy = int'(y); hn_at_vrise = (hn_out == hs_pol);
        end
        vlx = int'(x); vly = int'(y);
        vns++;
      end
      len++;
      @(negedge clk_in);
    end while (frame_start !== 1'b1 && len < 5000);
    if (frame_start !== 1'b1) begin
      checks++; errors++;
      $display("FAIL measure: frame did not end within %0d cycles", len);
    end
  endtask

  task automatic scan_line(output int dens, hns, first_hn);
    dens = 0; hns = 0; first_hn = -1;
    for (int i = 0; i < 1650; i++) begin
      if (i > 0) @(negedge clk_in);
      if (den_out) dens++;
      if (hn_out == hs_pol) begin
        hns++;
        if (first_hn < 0) first_hn = int'(x);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, len, dens, hns, vns, vfx, vfy, vlx, vly, fh;
    bit hv;

    // Tiny raster: 16 x 8 = 128 cycles.
    set_cfg(8, 2, 2, 4, 4, 1, 1, 2);
    do_reset();
    chk("reset_x", int'(x), 0);
    chk("reset_den", int'(den_out), 0);
    chk("reset_fs", int'(frame_start), 0);
    chk("reset_hn_idle", int'(hn_out), 0);
    wait_fs(n);
    chk("first_fs_latency", n, 1);
    measure(len, dens, hns, vns, vfx, vfy, vlx, vly, hv);
    chk("tiny_frame_len", len, 128);
    chk("tiny_den_cycles", dens, 32);
    chk("tiny_hs_cycles", hns, 16);
    chk("tiny_vs_cycles", vns, 16);
    chk("tiny_vs_rise_x", vfx, 10);
    chk("tiny_vs_rise_y", vfy, 5);
    chk("tiny_vs_rise_with_hs", int'(hv), 1);
    chk("tiny_vs_last_x", vlx, 9);
    chk("tiny_vs_last_y", vly, 6);
    chk("tiny_cfg_err", int'(cfg_err), 0);

    // Inverted polarity: active levels become low.
    hs_pol = 1'b0; vs_pol = 1'b0;
    wait_fs(n);
    measure(len, dens, hns, vns, vfx, vfy, vlx, vly, hv);
    chk("neg_hs_low_cycles", hns, 16);
    chk("neg_vs_low_cycles", vns, 16);
    chk("neg_vs_rise_x", vfx, 10);
    hs_pol = 1'b1; vs_pol = 1'b1;
    wait_fs(n);

    // Mid-frame h_active change takes effect only after the wrap.
    h_active = XB'(6);
    measure(len, dens, hns, vns, vfx, vfy, vlx, vly, hv);
    chk("chg_cur_frame_len", len, 128);
    chk("chg_tap", int'(total_active_pix), 6);
    measure(len, dens, hns, vns, vfx, vfy, vlx, vly, hv);
    chk("chg_new_frame_len", len, 112);
    chk("chg_new_den", dens, 24);

    // Illegal config at wrap: timing kept, cfg_err set; restore clears it.
    h_sync = '0;
    measure(len, dens, hns, vns, vfx, vfy, vlx, vly, hv);
    chk("ill_cfg_err_set", int'(cfg_err), 1);
    measure(len, dens, hns, vns, vfx, vfy, vlx, vly, hv);
    chk("ill_len_kept", len, 112);
    chk("ill_tap_kept", int'(total_active_pix), 6);
    h_sync = XB'(2);
    measure(len, dens, hns, vns, vfx, vfy, vlx, vly, hv);
    chk("ill_cfg_err_clear", int'(cfg_err), 0);

    // Reset with illegal config falls back to 720p.
    h_sync = '0;
    do_reset();
    chk("def_cfg_err", int'(cfg_err), 1);
    chk("def_tap", int'(total_active_pix), 1280);
    chk("def_tal", int'(total_active_lines), 720);
    wait_fs(n);
    scan_line(dens, hns, fh);
    chk("def_line_den", dens, 1280);
    chk("def_line_hs", hns, 40);
    chk("def_line_hs_x", fh, 1390);

    // Legal 720p reset.
    set_cfg(1280, 110, 40, 220, 720, 5, 5, 20);
    do_reset();
    chk("p720_cfg_err", int'(cfg_err), 0);
    chk("p720_model_frame", (m_h[0] + m_h[1] + m_h[2] + m_h[3]) * (m_v[0] + m_v[1] + m_v[2] + m_v[3]), 1237500);
    wait_fs(n);
    scan_line(dens, hns, fh);
    chk("p720_line_den", dens, 1280);
    chk("p720_line_hs", hns, 40);
    chk("p720_line_hs_x", fh, 1390);

    // Carry boundary: total 8191 fits 13 bits, 8192 does not.
    set_cfg(8000, 100, 41, 50, 4, 1, 1, 2);
    do_reset();
    chk("fit_cfg_err", int'(cfg_err), 0);
    chk("fit_tap", int'(total_active_pix), 8000);
    h_sync = XB'(42);
    do_reset();
    chk("carry_cfg_err", int'(cfg_err), 1);
    chk("carry_tap", int'(total_active_pix), 1280);

    // ce toggling halves the rate; reset mid-frame.
    set_cfg(8, 2, 2, 4, 4, 1, 1, 2);
    ce_mode = 1;
    do_reset();
    wait_fs(n);
    measure(len, dens, hns, vns, vfx, vfy, vlx, vly, hv);
    chk("ce_toggle_frame_len", len, 256);
    n = 0;
    while (!(x == XB'(5) && y == YB'(2)) && n < 1000) begin
      @(negedge clk_in);
      n++;
    end
    chk("midreset_den_before", int'(den_out), 1);
    reset = 1'b1;
    @(negedge clk_in);
    reset = 1'b0;
    chk("midreset_x", int'(x), 0);
    chk("midreset_y", int'(y), 0);
    chk("midreset_den", int'(den_out), 0);

    // Randomized traffic against the model.
    ce_mode = 2;
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk_in);
      if (reset) reset = 1'b0;
      if ($urandom_range(299) == 0) begin
        set_cfg($urandom_range(6, 1), $urandom_range(6, 1), $urandom_range(6, 1), $urandom_range(6, 1),
                $urandom_range(3, 1), $urandom_range(3, 1), $urandom_range(3, 1), $urandom_range(3, 1));
        if ($urandom_range(9) == 0) h_fp = '0;
        if ($urandom_range(9) == 0) v_bp = '0;
      end
      if ($urandom_range(499) == 0) hs_pol = ~hs_pol;
      if ($urandom_range(499) == 0) vs_pol = ~vs_pol;
      if ($urandom_range(1999) == 0 && ports_legal()) reset = 1'b1;
    end
    @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
